// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - stall/flush control bundle between the pipeline and pipe_ctrl_unit
interface pipe_ctrl_if #(
   parameter int NSTG   = 5,
   parameter int PC_W   = 32,
   parameter int WAIT_W = 4,
   parameter int CNT_W  = 32
);
   logic [NSTG-1:0]   stallreq_i;
   logic              memwait_start_i;
   logic [WAIT_W-1:0] memwait_i;
   logic              flushreq_i;
   logic [PC_W-1:0]   flush_pc_i;
   logic [NSTG:0]     stall_o;
   logic [NSTG-1:0]   flush_o;
   logic [PC_W-1:0]   new_pc_o;
   logic              new_pc_vld_o;
   logic              busy_o;
   logic [CNT_W-1:0]  cyc_cnt_o;
   logic [CNT_W-1:0]  stall_cnt_o;
   logic [CNT_W-1:0]  flush_cnt_o;

   modport master (
      output stallreq_i, memwait_start_i, memwait_i, flushreq_i, flush_pc_i,
      input  stall_o, flush_o, new_pc_o, new_pc_vld_o, busy_o,
             cyc_cnt_o, stall_cnt_o, flush_cnt_o
   );

   modport slave (
      input  stallreq_i, memwait_start_i, memwait_i, flushreq_i, flush_pc_i,
      output stall_o, flush_o, new_pc_o, new_pc_vld_o, busy_o,
             cyc_cnt_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - pipeline stall/flush controller with memory wait counter and PC redirect
// Optional performance counters are built when PERF_CNT_EN is defined.
module pipe_ctrl_unit #(
   parameter int NSTG     = 5,
   parameter int PC_W     = 32,
   parameter int WAIT_W   = 4,
   parameter int WAIT_STG = 3,
   parameter int CNT_W    = 32
) (
   input logic        clk,
   input logic        rst,
   pipe_ctrl_if.slave bus
);
   typedef enum logic [1:0] {RUN, WAIT, FLUSH} state_t;

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              pending;
   logic [PC_W-1:0]   pc_lat;
   logic [NSTG:0]     stall_mask;
   int                h;
   logic              h_vld;

   // Everything at or below the highest requesting stage holds, plus the register feeding it.
   always_comb begin
      h = 0;
      h_vld = 1'b0;
      stall_mask = '0;
      for (int k = 0; k < NSTG; k++) begin
         if (bus.stallreq_i[k]) begin
            h = k;
            h_vld = 1'b1;
         end
      end
      if (state == WAIT && (!h_vld || h < WAIT_STG)) begin
         h = WAIT_STG;
         h_vld = 1'b1;
      end
      if (h_vld) begin
         for (int j = 0; j <= NSTG; j++) begin
            if (j <= h + 1) stall_mask[j] = 1'b1;
         end
      end
   end

   assign bus.stall_o = (rst && state != FLUSH) ? stall_mask : '0;
   assign bus.busy_o  = (state == WAIT) | pending;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= RUN;
         wait_cnt         <= '0;
         pending          <= 1'b0;
         pc_lat           <= '0;
         bus.flush_o      <= '0;
         bus.new_pc_o     <= '0;
         bus.new_pc_vld_o <= 1'b0;
      end else begin
         bus.flush_o      <= '0;
         bus.new_pc_vld_o <= 1'b0;
         case (state)
            RUN: begin
               if (bus.flushreq_i) begin
                  pc_lat           <= bus.flush_pc_i;
                  pending          <= 1'b1;
                  state            <= FLUSH;
                  bus.flush_o      <= '1;
                  bus.new_pc_vld_o <= 1'b1;
                  bus.new_pc_o     <= bus.flush_pc_i;
               end else if (bus.memwait_start_i && bus.memwait_i != '0) begin
                  wait_cnt <= bus.memwait_i;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt - WAIT_W'(1);
               // Only the first redirect during a wait is kept.
               if (bus.flushreq_i && !pending) begin
                  pc_lat  <= bus.flush_pc_i;
                  pending <= 1'b1;
               end
               if (wait_cnt == WAIT_W'(1)) begin
                  if (pending || bus.flushreq_i) begin
                     state            <= FLUSH;
                     bus.flush_o      <= '1;
                     bus.new_pc_vld_o <= 1'b1;
                     bus.new_pc_o     <= pending ? pc_lat : bus.flush_pc_i;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            FLUSH: begin
               pending <= 1'b0;
               state   <= RUN;
               if (bus.flushreq_i) begin
                  pc_lat           <= bus.flush_pc_i;
                  pending          <= 1'b1;
                  state            <= FLUSH;
                  bus.flush_o      <= '1;
                  bus.new_pc_vld_o <= 1'b1;
                  bus.new_pc_o     <= bus.flush_pc_i;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] cyc_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc_cnt   <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         cyc_cnt <= cyc_cnt + CNT_W'(1);
         if (bus.stall_o[0])   stall_cnt <= stall_cnt + CNT_W'(1);
         if (state == FLUSH)   flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   assign bus.cyc_cnt_o   = cyc_cnt;
   assign bus.stall_cnt_o = stall_cnt;
   assign bus.flush_cnt_o = flush_cnt;
`else
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   assign bus.cyc_cnt_o   = CNT_ZERO;
   assign bus.stall_cnt_o = CNT_ZERO;
   assign bus.flush_cnt_o = CNT_ZERO;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - directed self-checking bench for pipe_ctrl_unit
module tb_pipe_ctrl_unit;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   pipe_ctrl_if #(.NSTG(5), .PC_W(32), .WAIT_W(4), .CNT_W(32)) bus();

   pipe_ctrl_unit #(.NSTG(5), .PC_W(32), .WAIT_W(4), .WAIT_STG(3), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.stallreq_i      = '0;
      bus.memwait_start_i = 1'b0;
      bus.memwait_i       = '0;
      bus.flushreq_i      = 1'b0;
      bus.flush_pc_i      = '0;
   endtask

   task automatic check_stall(input string tag, input logic [4:0] req, input logic [5:0] exp);
      bus.stallreq_i = req;
      #1;
      check(tag, bus.stall_o, exp);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b0;
      idle_inputs();
      bus.stallreq_i = 5'b00010;
      #12;
      check("rst_stall", bus.stall_o, 6'b0);
      check("rst_flush", bus.flush_o, 5'h0);
      check("rst_newpc", bus.new_pc_o, 32'h0);
      check("rst_vld", bus.new_pc_vld_o, 1'b0);
      check("rst_busy", bus.busy_o, 1'b0);
      check("rst_cyc", bus.cyc_cnt_o, 32'h0);
      rst = 1'b1;

      // combinational stall mask in RUN
      check_stall("mask_id", 5'b00010, 6'b000111);
      check("mask_id_flush", bus.flush_o, 5'h0);
      check_stall("mask_wb", 5'b10000, 6'b111111);
      check_stall("mask_if", 5'b00001, 6'b000011);
      check_stall("mask_multi", 5'b00101, 6'b001111);
      check_stall("mask_none", 5'b00000, 6'b000000);

      // memory wait of 3
      bus.memwait_start_i = 1'b1;
      bus.memwait_i = 4'd3;
      step();
      bus.memwait_start_i = 1'b0;
      bus.memwait_i = '0;
      for (int i = 0; i < 3; i++) begin
         check("wait_stall", bus.stall_o, 6'b011111);
         check("wait_busy", bus.busy_o, 1'b1);
         if (i == 1) begin
            check_stall("wait_wb_req", 5'b10000, 6'b111111);
            bus.stallreq_i = '0;
         end
         step();
      end
      check("wait_end_stall", bus.stall_o, 6'b0);
      check("wait_end_busy", bus.busy_o, 1'b0);

      // zero-length wait is ignored
      bus.memwait_start_i = 1'b1;
      step();
      bus.memwait_start_i = 1'b0;
      check("wait0_stall", bus.stall_o, 6'b0);
      check("wait0_busy", bus.busy_o, 1'b0);

      // flush from RUN
      bus.flushreq_i = 1'b1;
      bus.flush_pc_i = 32'hBFC0_0380;
      step();
      bus.flushreq_i = 1'b0;
      bus.flush_pc_i = '0;
      check("fl_flush", bus.flush_o, 5'h1F);
      check("fl_vld", bus.new_pc_vld_o, 1'b1);
      check("fl_pc", bus.new_pc_o, 32'hBFC0_0380);
      check_stall("fl_stall_ovr", 5'b00010, 6'b0);
      step();
      check("fl_done_flush", bus.flush_o, 5'h0);
      check("fl_done_vld", bus.new_pc_vld_o, 1'b0);
      check("fl_hold_pc", bus.new_pc_o, 32'hBFC0_0380);
      check("fl_done_stall", bus.stall_o, 6'b000111);
      bus.stallreq_i = '0;

      // flush beats memwait in the same cycle
      bus.flushreq_i = 1'b1;
      bus.flush_pc_i = 32'h0000_1000;
      bus.memwait_start_i = 1'b1;
      bus.memwait_i = 4'd3;
      step();
      idle_inputs();
      check("fvm_flush", bus.flush_o, 5'h1F);
      check("fvm_pc", bus.new_pc_o, 32'h0000_1000);
      step();
      check("fvm_stall", bus.stall_o, 6'b0);
      check("fvm_busy", bus.busy_o, 1'b0);

      // two flushes during a wait of 2: only the first is issued, after the wait
      bus.memwait_start_i = 1'b1;
      bus.memwait_i = 4'd2;
      step();
      idle_inputs();
      bus.flushreq_i = 1'b1;
      bus.flush_pc_i = 32'hAAAA_0000;
      step();
      check("wf_no_early", bus.flush_o, 5'h0);
      check("wf_busy", bus.busy_o, 1'b1);
      check("wf_stall", bus.stall_o, 6'b011111);
      bus.flush_pc_i = 32'hBBBB_0000;
      step();
      idle_inputs();
      check("wf_flush", bus.flush_o, 5'h1F);
      check("wf_pc_a", bus.new_pc_o, 32'hAAAA_0000);
      check("wf_vld", bus.new_pc_vld_o, 1'b1);
      step();
      check("wf_once", bus.flush_o, 5'h0);
      check("wf_idle_busy", bus.busy_o, 1'b0);

      // new request during FLUSH repeats the flush
      bus.flushreq_i = 1'b1;
      bus.flush_pc_i = 32'h0000_00C0;
      step();
      bus.flush_pc_i = 32'h0000_00D0;
      step();
      idle_inputs();
      check("ff_repeat", bus.flush_o, 5'h1F);
      check("ff_pc", bus.new_pc_o, 32'h0000_00D0);
      step();
      check("ff_end", bus.flush_o, 5'h0);

      // reset in the middle of a wait
      bus.memwait_start_i = 1'b1;
      bus.memwait_i = 4'd5;
      step();
      idle_inputs();
      check("rw_busy", bus.busy_o, 1'b1);
      rst = 1'b0;
      #1;
      check("rw_stall", bus.stall_o, 6'b0);
      check("rw_busy0", bus.busy_o, 1'b0);
      check("rw_newpc", bus.new_pc_o, 32'h0);
      #2;
      rst = 1'b1;
      #1;
      check("rw_rel_stall", bus.stall_o, 6'b0);
      step();
      check("rw_run", bus.stall_o, 6'b0);

      // performance counters over exactly 10 cycles from reset release
      @(negedge clk);
      rst = 1'b0;
      #1;
      rst = 1'b1;
      for (int c = 0; c < 10; c++) begin
         idle_inputs();
         if (c < 4) bus.stallreq_i = 5'b00001;
         if (c == 4) begin
            bus.flushreq_i = 1'b1;
            bus.flush_pc_i = 32'h0000_0040;
         end
         @(posedge clk);
         #1;
      end
      idle_inputs();
`ifdef PERF_CNT_EN
      check("perf_cyc", bus.cyc_cnt_o, 32'd10);
      check("perf_stall", bus.stall_cnt_o, 32'd4);
      check("perf_flush", bus.flush_cnt_o, 32'd1);
`else
      check("perf_cyc", bus.cyc_cnt_o, 32'd0);
      check("perf_stall", bus.stall_cnt_o, 32'd0);
      check("perf_flush", bus.flush_cnt_o, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
